// File: rtl/usb_desc_stream.sv
`default_nettype none
// ============================================================================
// usb_desc_stream : GET_DESCRIPTOR decode and EP0 IN descriptor byte streamer.
// Optional feature macro: USB_DESC_OTHER_SPEED_EN (type 0x07 other-speed config)
// Rev 1.0
// ============================================================================
module usb_desc_stream #(
  parameter int ADDR_W  = 16,
  parameter int NUM_STR = 8,
  parameter int MPS     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [7:0]                req_type_i,
  input  logic [7:0]                req_index_i,
  input  logic [15:0]               req_length_i,
  input  logic                      hs_mode_i,
  input  logic                      abort_i,
  input  logic [15:0]               dev_addr_i,
  input  logic [15:0]               dev_len_i,
  input  logic [15:0]               qual_addr_i,
  input  logic [15:0]               qual_len_i,
  input  logic [15:0]               fscfg_addr_i,
  input  logic [15:0]               fscfg_len_i,
  input  logic [15:0]               hscfg_addr_i,
  input  logic [15:0]               hscfg_len_i,
  input  logic [15:0]               hidrpt_addr_i,
  input  logic [15:0]               hidrpt_len_i,
  input  logic [15:0]               bos_addr_i,
  input  logic [15:0]               bos_len_i,
  input  logic [16*(NUM_STR+1)-1:0] str_addr_i,
  input  logic [16*(NUM_STR+1)-1:0] str_len_i,
  output logic [ADDR_W-1:0]         rom_raddr_o,
  input  logic [7:0]                rom_rdata_i,
  output logic [7:0]                out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic                      out_zlp_o,
  output logic                      req_stall_o
);

  localparam int PW = $clog2(MPS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_ZLP    = 2'd3
  } state_t;

  state_t            state_q;
  logic [15:0]       xfer_len_q;
  logic [15:0]       fcnt_q;
  logic [15:0]       byte_cnt_q;
  logic [PW-1:0]     pkt_cnt_q;
  logic              short_q;
  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] raddr_d;
  logic [7:0]        out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              out_zlp_q;
  logic              stall_q;

  logic              src_ok_w;
  logic [15:0]       src_addr_w;
  logic [15:0]       src_len_w;
  logic [15:0]       xl_w;
  logic              accept_w;
  logic              load_w;
  logic              more_w;
  logic              fire_w;
  logic              last_w;
  logic              final_w;
  logic [7:0]        byte_w;

  always_comb begin
    src_ok_w   = 1'b1;
    src_addr_w = '0;
    src_len_w  = '0;
    case (req_type_i)
      8'h01: begin src_addr_w = dev_addr_i;    src_len_w = dev_len_i;    end
      8'h06: begin src_addr_w = qual_addr_i;   src_len_w = qual_len_i;   end
      8'h0F: begin src_addr_w = bos_addr_i;    src_len_w = bos_len_i;    end
      8'h22: begin src_addr_w = hidrpt_addr_i; src_len_w = hidrpt_len_i; end
      8'h02: begin
        src_ok_w   = (req_index_i == 8'h00);
        src_addr_w = hs_mode_i ? hscfg_addr_i : fscfg_addr_i;
        src_len_w  = hs_mode_i ? hscfg_len_i  : fscfg_len_i;
      end
`ifdef USB_DESC_OTHER_SPEED_EN
      8'h07: begin
        // Other-speed view: the configuration of the speed we are NOT running at.
        src_ok_w   = (req_index_i == 8'h00);
        src_addr_w = hs_mode_i ? fscfg_addr_i : hscfg_addr_i;
        src_len_w  = hs_mode_i ? fscfg_len_i  : hscfg_len_i;
      end
`endif
      8'h03: begin
        src_ok_w = 1'b0;
        for (int k = 0; k <= NUM_STR; k++) begin
          if (req_index_i == 8'(k)) begin
            src_ok_w   = 1'b1;
            src_addr_w = str_addr_i[16*k +: 16];
            src_len_w  = str_len_i[16*k +: 16];
          end
        end
      end
      default: src_ok_w = 1'b0;
    endcase
    if (src_len_w == 16'd0) src_ok_w = 1'b0;
  end

  assign xl_w     = (src_len_w < req_length_i) ? src_len_w : req_length_i;
  assign accept_w = req_valid_i && (state_q == S_IDLE) && !abort_i;
  assign fire_w   = out_valid_q && out_ready_i;
  assign load_w   = (state_q == S_STREAM) && rd_vld_q && (!out_valid_q || out_ready_i);
  assign more_w   = (fcnt_q + 16'd1) < xfer_len_q;
  assign last_w   = (&fcnt_q[PW-1:0]) || !more_w;
  assign final_w  = (byte_cnt_q == xfer_len_q - 16'd1);
  // ROM address only advances when the byte on rom_rdata is consumed, so a
  // stalled sink simply re-reads the same address with no skid storage.
  assign raddr_d  = (load_w && more_w) ? rd_addr_q + ADDR_W'(1) : rd_addr_q;

`ifdef USB_DESC_OTHER_SPEED_EN
  logic os_q;
  always_ff @(posedge clk) begin
    if (rst)           os_q <= 1'b0;
    else if (accept_w) os_q <= (req_type_i == 8'h07);
  end
  assign byte_w = (os_q && fcnt_q == 16'd1) ? 8'h07 : rom_rdata_i;
`else
  assign byte_w = rom_rdata_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      xfer_len_q  <= '0;
      fcnt_q      <= '0;
      byte_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      short_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_zlp_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (abort_i) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_zlp_q   <= 1'b0;
        out_data_q  <= '0;
        rd_vld_q    <= 1'b0;
        fcnt_q      <= '0;
        byte_cnt_q  <= '0;
        pkt_cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept_w) begin
              if (!src_ok_w) begin
                stall_q <= 1'b1;
              end else begin
                xfer_len_q <= xl_w;
                short_q    <= (xl_w < req_length_i);
                fcnt_q     <= '0;
                byte_cnt_q <= '0;
                pkt_cnt_q  <= '0;
                if (xl_w == 16'd0) begin
                  state_q     <= S_ZLP;
                  out_valid_q <= 1'b1;
                  out_zlp_q   <= 1'b1;
                  out_last_q  <= 1'b1;
                  out_data_q  <= '0;
                end else begin
                  state_q   <= S_PRIME;
                  rd_addr_q <= ADDR_W'(src_addr_w);
                end
              end
            end
          end
          S_PRIME: begin
            state_q  <= S_STREAM;
            rd_vld_q <= 1'b1;
          end
          S_STREAM: begin
            rd_addr_q <= raddr_d;
            if (load_w) begin
              out_valid_q <= 1'b1;
              out_data_q  <= byte_w;
              out_last_q  <= last_w;
              fcnt_q      <= fcnt_q + 16'd1;
              rd_vld_q    <= more_w;
            end else if (fire_w) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
            if (fire_w) begin
              if (final_w) begin
                byte_cnt_q <= '0;
                pkt_cnt_q  <= '0;
                // A full final packet on a short transfer needs a ZLP terminator.
                if (short_q && (&pkt_cnt_q)) begin
                  state_q     <= S_ZLP;
                  out_valid_q <= 1'b1;
                  out_zlp_q   <= 1'b1;
                  out_last_q  <= 1'b1;
                  out_data_q  <= '0;
                end else begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  out_data_q  <= '0;
                end
              end else begin
                byte_cnt_q <= byte_cnt_q + 16'd1;
                pkt_cnt_q  <= out_last_q ? '0 : pkt_cnt_q + PW'(1);
              end
            end
          end
          S_ZLP: begin
            if (fire_w) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_zlp_q   <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rom_raddr_o = raddr_d;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_zlp_o   = out_zlp_q;
  assign req_stall_o = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_desc_stream.sv
`default_nettype none
// ============================================================================
// tb_usb_desc_stream : directed self-checking bench for usb_desc_stream.
// Rev 1.0
// ============================================================================
module tb_usb_desc_stream;

  localparam int ADDR_W  = 16;
  localparam int NUM_STR = 8;
  localparam int MPS     = 64;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      req_valid;
  logic                      req_ready;
  logic [7:0]                req_type;
  logic [7:0]                req_index;
  logic [15:0]               req_length;
  logic                      hs_mode;
  logic                      abort;
  logic [15:0]               dev_addr, dev_len, qual_addr, qual_len;
  logic [15:0]               fscfg_addr, fscfg_len, hscfg_addr, hscfg_len;
  logic [15:0]               hidrpt_addr, hidrpt_len, bos_addr, bos_len;
  logic [16*(NUM_STR+1)-1:0] str_addr, str_len;
  logic [ADDR_W-1:0]         rom_raddr;
  logic [7:0]                rom_rdata;
  logic [7:0]                out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      out_zlp;
  logic                      req_stall;

  int n_chk  = 0;
  int n_fail = 0;

  usb_desc_stream #(.ADDR_W(ADDR_W), .NUM_STR(NUM_STR), .MPS(MPS)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_type_i(req_type), .req_index_i(req_index), .req_length_i(req_length),
    .hs_mode_i(hs_mode), .abort_i(abort),
    .dev_addr_i(dev_addr), .dev_len_i(dev_len),
    .qual_addr_i(qual_addr), .qual_len_i(qual_len),
    .fscfg_addr_i(fscfg_addr), .fscfg_len_i(fscfg_len),
    .hscfg_addr_i(hscfg_addr), .hscfg_len_i(hscfg_len),
    .hidrpt_addr_i(hidrpt_addr), .hidrpt_len_i(hidrpt_len),
    .bos_addr_i(bos_addr), .bos_len_i(bos_len),
    .str_addr_i(str_addr), .str_len_i(str_len),
    .rom_raddr_o(rom_raddr), .rom_rdata_i(rom_rdata),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .out_zlp_o(out_zlp), .req_stall_o(req_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  always @(posedge clk) rom_rdata <= rom_f(rom_raddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_xfer(input string nm, input logic [7:0] typ, input logic [7:0] idx,
                          input logic [15:0] wlen, input logic hs, input logic [15:0] start,
                          input logic [15:0] dlen, input int pat, input int abort_at,
                          input bit subst);
    int xl, got, cyc, first_c, last_c;
    bit exp_zlp, done, held, aborted, rdy;
    logic [7:0] hd, ed;
    logic hl;
    xl = (dlen < wlen) ? int'(dlen) : int'(wlen);
    exp_zlp = (xl == 0) || ((xl < int'(wlen)) && (xl % MPS == 0));
    check({nm, "_rdy0"}, req_ready, 1);
    req_type = typ; req_index = idx; req_length = wlen; hs_mode = hs; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    got = 0; cyc = 0; first_c = 0; last_c = 0;
    done = 0; held = 0; aborted = 0; hd = '0; hl = 1'b0;
    while (!done && cyc < 2000) begin
      rdy = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      if (held) begin
        check({nm, "_hold_v"}, out_valid, 1);
        check({nm, "_hold_d"}, out_data, hd);
        check({nm, "_hold_l"}, out_last, hl);
      end
      held = 0;
      if (out_valid) begin
        if (abort_at != 0 && got + 1 == abort_at) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          out_ready = 1'b1;
          check({nm, "_abort_v"}, out_valid, 0);
          check({nm, "_abort_rdy"}, req_ready, 1);
          check({nm, "_abort_stall"}, req_stall, 0);
          aborted = 1; done = 1;
        end else if (rdy) begin
          if (got < xl) begin
            ed = (subst && got == 1) ? 8'h07 : rom_f(start + 16'(got));
            check({nm, "_data"}, out_data, ed);
            check({nm, "_last"}, out_last, ((got % MPS) == MPS - 1) || (got == xl - 1));
            check({nm, "_zlp0"}, out_zlp, 0);
            if (got == 0) first_c = cyc;
            last_c = cyc;
            got++;
            if (got == xl && !exp_zlp) done = 1;
          end else begin
            check({nm, "_zlp"}, out_zlp, 1);
            check({nm, "_zlp_last"}, out_last, 1);
            check({nm, "_zlp_data"}, out_data, 0);
            done = 1;
          end
        end else begin
          held = 1; hd = out_data; hl = out_last;
        end
      end
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    out_ready = 1'b1;
    check({nm, "_done"}, done, 1);
    if (aborted) begin
      @(negedge clk);
      check({nm, "_abort_v2"}, out_valid, 0);
    end else begin
      check({nm, "_idle_v"}, out_valid, 0);
      check({nm, "_idle_rdy"}, req_ready, 1);
      if (pat == 0 && xl > 0) check({nm, "_gap"}, last_c - first_c, xl - 1);
      if (xl > 0)
        check({nm, "_raddr"}, (rom_raddr >= start) && (rom_raddr <= start + 16'(xl - 1)), 1);
    end
  endtask

  task automatic run_stall(input string nm, input logic [7:0] typ, input logic [7:0] idx,
                           input logic hs);
    check({nm, "_rdy0"}, req_ready, 1);
    req_type = typ; req_index = idx; req_length = 16'h0040; hs_mode = hs; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, "_stall"}, req_stall, 1);
    check({nm, "_v"}, out_valid, 0);
    @(negedge clk);
    check({nm, "_stall_end"}, req_stall, 0);
    check({nm, "_v2"}, out_valid, 0);
    check({nm, "_rdy"}, req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vseen;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_index = '0; req_length = '0;
    hs_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
    dev_addr    = 16'h0100; dev_len    = 16'd18;
    fscfg_addr  = 16'h0200; fscfg_len  = 16'd273;
    hscfg_addr  = 16'h0400; hscfg_len  = 16'd64;
    qual_addr   = 16'h0600; qual_len   = 16'd10;
    bos_addr    = 16'h0700; bos_len    = 16'd0;
    hidrpt_addr = 16'h0800; hidrpt_len = 16'd64;
    for (int k = 0; k <= NUM_STR; k++) begin
      str_addr[16*k +: 16] = 16'h1000 + 16'(k * 16'h40);
      str_len[16*k +: 16]  = 16'd4 + 16'(2 * k);
    end
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_zlp", out_zlp, 0);
    check("rst_stall", req_stall, 0);
    check("rst_ready", req_ready, 1);
    check("rst_data", out_data, 0);
    check("rst_raddr", rom_raddr, 0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer("dev",      8'h01, 8'h00, 16'h0040, 1'b0, 16'h0100, 16'd18,  0, 0, 0);
    run_xfer("fscfg",    8'h02, 8'h00, 16'hFFFF, 1'b0, 16'h0200, 16'd273, 0, 0, 0);
    run_xfer("hscfg255", 8'h02, 8'h00, 16'd255,  1'b1, 16'h0400, 16'd64,  0, 0, 0);
    run_xfer("hscfg64",  8'h02, 8'h00, 16'd64,   1'b1, 16'h0400, 16'd64,  0, 0, 0);
    run_xfer("str3",     8'h03, 8'h03, 16'h0040, 1'b0, 16'h10C0, 16'd10,  0, 0, 0);
    run_xfer("langid",   8'h03, 8'h00, 16'h00FF, 1'b0, 16'h1000, 16'd4,   1, 0, 0);
    run_xfer("qual5",    8'h06, 8'h00, 16'd5,    1'b0, 16'h0600, 16'd10,  1, 0, 0);
    run_xfer("devzlp",   8'h01, 8'h00, 16'd0,    1'b0, 16'h0100, 16'd18,  0, 0, 0);
    run_xfer("hidtog",   8'h22, 8'h00, 16'd64,   1'b0, 16'h0800, 16'd64,  1, 0, 0);
    run_xfer("hidabort", 8'h22, 8'h00, 16'd64,   1'b0, 16'h0800, 16'd64,  1, 5, 0);

    run_stall("str9",  8'h03, 8'h09, 1'b0);
    run_stall("cfgi1", 8'h02, 8'h01, 1'b0);
    run_stall("bos0",  8'h0F, 8'h00, 1'b0);
    run_stall("type5", 8'h05, 8'h00, 1'b0);
`ifdef USB_DESC_OTHER_SPEED_EN
    run_xfer("osc", 8'h07, 8'h00, 16'd20, 1'b1, 16'h0200, 16'd273, 0, 0, 1);
`else
    run_stall("type7", 8'h07, 8'h00, 1'b1);
`endif

    // request coinciding with abort must be ignored
    req_type = 8'h01; req_index = 8'h00; req_length = 16'h0040; req_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0;
    check("reqabort_rdy", req_ready, 1);
    check("reqabort_stall", req_stall, 0);
    vseen = 0;
    repeat (4) begin
      @(negedge clk);
      vseen |= out_valid;
    end
    check("reqabort_v", vseen, 0);

    // reset in the middle of a transfer discards it
    req_type = 8'h01; req_index = 8'h00; req_length = 16'h0040; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midrst_started", n, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", req_ready, 1);
    check("midrst_raddr", rom_raddr, 0);
    vseen = 0;
    repeat (20) begin
      @(negedge clk);
      vseen |= out_valid;
    end
    check("midrst_v", vseen, 0);

    run_xfer("post", 8'h01, 8'h00, 16'd8, 1'b0, 16'h0100, 16'd18, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
